// File: rtl/fadd_arbiter.sv
// Round-robin arbiter that shares one pipelined fadd between two requesters.
// Each issued op is tracked by valid/owner/tag slots so its result returns to the right port.
module fadd_arbiter #(
  parameter int LATENCY = 3,
  parameter int TAGW    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [31:0]                     req_x1_0,
  input  logic [31:0]                     req_x2_0,
  input  logic [31:0]                     req_x1_1,
  input  logic [31:0]                     req_x2_1,
  input  logic [TAGW-1:0]                 req_tag_0,
  input  logic [TAGW-1:0]                 req_tag_1,
  output logic [31:0]                     fadd_x1,
  output logic [31:0]                     fadd_x2,
  input  logic [31:0]                     fadd_y,
  output logic [1:0]                      rsp_valid,
  output logic [31:0]                     rsp_y,
  output logic [TAGW-1:0]                 rsp_tag,
  input  logic                            drain_req,
  output logic                            drain_done,
  output logic [$clog2(LATENCY+2)-1:0]    inflight
);

  // Sustained issue keeps LATENCY+1 ops outstanding, so the count needs room for that value.
  localparam int CNT_W = $clog2(LATENCY+2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t          state;
  logic            rr;
  logic            xfer;
  logic            sel;

  logic            iss_vld_p0;
  logic            iss_own_p0;
  logic [TAGW-1:0] iss_tag_p0;

  logic [LATENCY-1:0] slot_vld_p1;
  logic [LATENCY-1:0] slot_own_p1;
  logic [TAGW-1:0]    slot_tag_p1 [LATENCY];
  logic               head_vld;

  always_comb begin
    req_ready = 2'b00;
    if (!rst && state == RUN) begin
      if (req_valid == 2'b11) req_ready = rr ? 2'b10 : 2'b01;
      else                    req_ready = req_valid;
    end
  end

  assign xfer     = |req_ready;
  assign sel      = req_ready[1];
  assign head_vld = slot_vld_p1[LATENCY-1];

  // Stage p0: operands registered toward the fadd
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_p0 <= 1'b0;
      fadd_x1    <= '0;
      fadd_x2    <= '0;
    end else begin
      iss_vld_p0 <= xfer;
      if (xfer) begin
        fadd_x1 <= sel ? req_x1_1 : req_x1_0;
        fadd_x2 <= sel ? req_x2_1 : req_x2_0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      iss_own_p0 <= sel;
      iss_tag_p0 <= sel ? req_tag_1 : req_tag_0;
    end
  end

  // Stage p1: slot tracker aligned with the fadd's internal pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_p1 <= '0;
    end else begin
      slot_vld_p1[0] <= iss_vld_p0;
      for (int i = 1; i < LATENCY; i++) slot_vld_p1[i] <= slot_vld_p1[i-1];
    end
  end

  always_ff @(posedge clk) begin
    slot_own_p1[0] <= iss_own_p0;
    slot_tag_p1[0] <= iss_tag_p0;
    for (int i = 1; i < LATENCY; i++) begin
      slot_own_p1[i] <= slot_own_p1[i-1];
      slot_tag_p1[i] <= slot_tag_p1[i-1];
    end
  end

  // Stage p2: result capture and return to the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 2'b00;
      rsp_y     <= '0;
      rsp_tag   <= '0;
    end else begin
      rsp_valid <= head_vld ? (slot_own_p1[LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
      if (head_vld) begin
        rsp_y   <= fadd_y;
        rsp_tag <= slot_tag_p1[LATENCY-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({xfer, head_vld})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      drain_done <= 1'b0;
      rr         <= 1'b0;
    end else begin
      if (xfer) rr <= ~sel;
      case (state)
        RUN: if (drain_req) state <= DRAIN;
        DRAIN: begin
          if (inflight == '0) begin
            state      <= DRAINED;
            drain_done <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state      <= RUN;
            drain_done <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter with a behavioural fadd pipeline built from known sums.
module tb_fadd_arbiter;
  localparam int LAT = 3;
  localparam int TW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [31:0]       req_x1_0, req_x2_0, req_x1_1, req_x2_1;
  logic [TW-1:0]     req_tag_0, req_tag_1;
  logic [31:0]       fadd_x1, fadd_x2, fadd_y;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_y;
  logic [TW-1:0]     rsp_tag;
  logic              drain_req;
  logic              drain_done;
  logic [$clog2(LAT+2)-1:0] inflight;

  fadd_arbiter #(.LATENCY(LAT), .TAGW(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x1_0(req_x1_0), .req_x2_0(req_x2_0), .req_x1_1(req_x1_1), .req_x2_1(req_x2_1),
    .req_tag_0(req_tag_0), .req_tag_1(req_tag_1),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_tag(rsp_tag),
    .drain_req(drain_req), .drain_done(drain_done), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Known single-precision sums used by the tests; anything else maps to a^b.
  function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h3F000000_3F800000: return 32'h3FC00000;
      64'hBF800000_3F800000: return 32'h00000000;
      default:               return a ^ b;
    endcase
  endfunction

  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= fadd_ref(fadd_x1, fadd_x2);
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fadd_y = fpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          g_port[$];
  int          g_cyc[$];
  logic [1:0]  r_vld[$];
  logic [31:0] r_y[$];
  logic [TW-1:0] r_tag[$];
  int          r_cyc[$];

  // Transfers are attributed to the upcoming edge, responses to the edge that registered them.
  always begin
    @(negedge clk);
    #4;
    if (|(req_valid & req_ready)) begin
      g_port.push_back(req_ready[1] ? 1 : 0);
      g_cyc.push_back(cyc + 1);
    end
    if (|rsp_valid) begin
      r_vld.push_back(rsp_valid);
      r_y.push_back(rsp_y);
      r_tag.push_back(rsp_tag);
      r_cyc.push_back(cyc);
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_log();
    g_port.delete(); g_cyc.delete();
    r_vld.delete(); r_y.delete(); r_tag.delete(); r_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; drain_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int t0, td;
  int exp_port [6];

  initial begin
    rst = 1'b1; req_valid = 2'b11; drain_req = 1'b0;
    req_x1_0 = '0; req_x2_0 = '0; req_x1_1 = '0; req_x2_1 = '0;
    req_tag_0 = '0; req_tag_1 = '0;
    tick(); tick();
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_y", rsp_y, 32'h0);
    check("rst_fadd_x1", fadd_x1, 32'h0);
    check("rst_inflight", inflight, 0);
    check("rst_drain_done", drain_done, 1'b0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single op on port 0
    clear_log();
    req_valid = 2'b01; req_x1_0 = 32'h3F800000; req_x2_0 = 32'h40000000; req_tag_0 = 4'd5;
    tick();
    req_valid = 2'b00;
    check("single_inflight1", inflight, 1);
    check("single_fadd_x1", fadd_x1, 32'h3F800000);
    check("single_fadd_x2", fadd_x2, 32'h40000000);
    repeat (LAT + 3) tick();
    check("single_nrsp", r_vld.size(), 1);
    if (r_vld.size() >= 1 && g_cyc.size() >= 1) begin
      check("single_vld", r_vld[0], 2'b01);
      check("single_y", r_y[0], 32'h40400000);
      check("single_tag", r_tag[0], 4'd5);
      check("single_lat", r_cyc[0] - g_cyc[0], LAT + 1);
    end
    check("single_inflight0", inflight, 0);
    check("single_pulse", rsp_valid, 2'b00);
    check("single_hold_y", rsp_y, 32'h40400000);

    // Contention from a fresh rr pointer
    do_reset();
    clear_log();
    req_x1_0 = 32'h3F800000; req_x2_0 = 32'h3F800000;
    req_x1_1 = 32'h3F000000; req_x2_1 = 32'h3F800000;
    req_tag_0 = 4'd0; req_tag_1 = 4'd8;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] rdy;
      req_valid = 2'b11;
      #1 rdy = req_ready;
      tick();
      if (rdy[0]) req_tag_0 = req_tag_0 + 4'd1;
      if (rdy[1]) req_tag_1 = req_tag_1 + 4'd1;
    end
    req_valid = 2'b00;
    repeat (LAT + 3) tick();
    check("cont_ngrant", g_port.size(), 6);
    check("cont_nrsp", r_vld.size(), 6);
    if (g_port.size() == 6 && r_vld.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("cont_grant%0d", k), g_port[k], k % 2);
        check($sformatf("cont_vld%0d", k), r_vld[k], (k % 2) ? 2'b10 : 2'b01);
        check($sformatf("cont_y%0d", k), r_y[k], (k % 2) ? 32'h3FC00000 : 32'h40000000);
        check($sformatf("cont_tag%0d", k), r_tag[k], (k % 2) ? (8 + k / 2) : (k / 2));
        check($sformatf("cont_gap%0d", k), r_cyc[k] - r_cyc[0], k);
      end
    end

    // Port 1 joins a continuous port 0 stream
    clear_log();
    exp_port = '{0, 0, 1, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      req_valid = (k >= 2) ? 2'b11 : 2'b01;
      tick();
    end
    req_valid = 2'b00;
    repeat (LAT + 3) tick();
    check("starve_ngrant", g_port.size(), 6);
    if (g_port.size() == 6)
      for (int k = 0; k < 6; k++) check($sformatf("starve_grant%0d", k), g_port[k], exp_port[k]);

    // Drain with drain_req raised on the third transfer
    clear_log();
    req_x1_0 = 32'h3F800000; req_x2_0 = 32'h40000000;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b01; req_tag_0 = 4'(k);
      if (k == 2) drain_req = 1'b1;
      tick();
    end
    t0 = -1; td = -1;
    for (int k = 0; k < 12 && td < 0; k++) begin
      #1;
      check("drain_ready", req_ready, 2'b00);
      if (inflight == 0 && t0 < 0) t0 = cyc;
      if (drain_done && td < 0) td = cyc;
      if (td < 0) tick();
    end
    check("drain_reached", td >= 0, 1'b1);
    check("drain_done_lag", td - t0, 1);
    check("drain_ngrant", g_port.size(), 3);
    check("drain_nrsp", r_vld.size(), 3);
    if (r_vld.size() == 3)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("drain_tag%0d", k), r_tag[k], k);
        check($sformatf("drain_y%0d", k), r_y[k], 32'h40400000);
      end
    drain_req = 1'b0;
    tick();
    #1;
    check("resume_done", drain_done, 1'b0);
    check("resume_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    repeat (LAT + 3) tick();

    // Reset while two ops are in flight
    clear_log();
    req_valid = 2'b10; req_tag_1 = 4'd2;
    tick();
    req_valid = 2'b01; req_tag_0 = 4'd1;
    tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_inflight", inflight, 0);
    repeat (10) tick();
    check("rstmid_nrsp", r_vld.size(), 0);
    check("rstmid_inflight2", inflight, 0);
    req_valid = 2'b11;
    #1 check("rstmid_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    repeat (LAT + 3) tick();

    // Negative operand pass-through on port 1
    clear_log();
    req_valid = 2'b10; req_x1_1 = 32'hBF800000; req_x2_1 = 32'h3F800000; req_tag_1 = 4'd7;
    tick();
    req_valid = 2'b00;
    repeat (LAT + 3) tick();
    check("sign_nrsp", r_vld.size(), 1);
    if (r_vld.size() == 1) begin
      check("sign_vld", r_vld[0], 2'b10);
      check("sign_y", r_y[0], 32'h00000000);
      check("sign_tag", r_tag[0], 4'd7);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
